disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_pkg.sv | 32 +++
 rtl/disp_arbiter_hex_to_seg7.sv | 33 +++
 rtl/disp_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_disp_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter: FSM encoding, dwell default,
// and active-low seven-segment patterns ({g..a}).
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam int DWELL_TICKS_DEF = 120;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/disp_arbiter_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder ({g..a}).
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // full 0-F decode; default only guards against unknown inputs
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_arbiter.sv
// Two-requester display arbiter with dwell-limited preemption and a
// four-digit multiplexed hex display. Optional macro: DISP_LEAD_BLANK_EN.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int DWELL_TICKS = DWELL_TICKS_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN240,
  input  logic        REQ0,
  input  logic [15:0] DATA0,
  input  logic        REQ1,
  input  logic [15:0] DATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        OWNER,
  output logic [3:0]  AN4,
  output logic [6:0]  SEG7
);

  localparam int DW = (DWELL_TICKS < 1) ? 1 : $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS);

  state_t        state_r, state_s;
  logic          gnt0_r, gnt1_r, gnt0_s, gnt1_s;
  logic          change_s, entry_s, expired_s;
  logic [DW-1:0] dwell_r;
  logic          owner_r, last_r;
  logic [15:0]   disp_r;
  logic [1:0]    idx_r;
  logic          lit_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic [3:0]    nib_s;
  logic [6:0]    dec_s, seg_s;

  assign expired_s = (dwell_r == DWELL_MAX);

  // state register and registered grants
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt0_r  <= gnt0_s;
      gnt1_r  <= gnt1_s;
    end
  end

  // next-state: tie in IDLE goes to the requester not served last
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (REQ0 && REQ1)  state_s = last_r ? ST_GRANT0 : ST_GRANT1;
        else if (REQ0)     state_s = ST_GRANT0;
        else if (REQ1)     state_s = ST_GRANT1;
        else               state_s = ST_IDLE;
      end
      ST_GRANT0: begin
        if (!REQ0)                 state_s = REQ1 ? ST_GRANT1 : ST_IDLE;
        else if (REQ1 && expired_s) state_s = ST_GRANT1;
        else                       state_s = ST_GRANT0;
      end
      ST_GRANT1: begin
        if (!REQ1)                 state_s = REQ0 ? ST_GRANT0 : ST_IDLE;
        else if (REQ0 && expired_s) state_s = ST_GRANT0;
        else                       state_s = ST_GRANT1;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so grants register with it
  always_comb begin
    gnt0_s   = (state_s == ST_GRANT0);
    gnt1_s   = (state_s == ST_GRANT1);
    change_s = (state_s != state_r);
    entry_s  = change_s && (state_s != ST_IDLE);
  end

  // dwell counter: any state change clears it, even on an EN240 cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dwell_r <= '0;
    end else if (change_s) begin
      dwell_r <= '0;
    end else if ((state_r != ST_IDLE) && EN240 && !expired_s) begin
      dwell_r <= dwell_r + DW'(1);
    end else begin
      dwell_r <= dwell_r;
    end
  end

  // owner and last-served; last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else if (entry_s) begin
      owner_r <= (state_s == ST_GRANT1);
      last_r  <= (state_s == ST_GRANT1);
    end else begin
      owner_r <= owner_r;
      last_r  <= last_r;
    end
  end

  // display register follows the granted requester, holds otherwise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      disp_r <= 16'h0000;
    end else if (gnt0_r) begin
      disp_r <= DATA0;
    end else if (gnt1_r) begin
      disp_r <= DATA1;
    end else begin
      disp_r <= disp_r;
    end
  end

  // scan index; the first EN240 after reset only lights digit 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_r <= 2'd0;
      lit_r <= 1'b0;
    end else if (EN240) begin
      idx_r <= lit_r ? idx_r + 2'd1 : idx_r;
      lit_r <= 1'b1;
    end else begin
      idx_r <= idx_r;
      lit_r <= lit_r;
    end
  end

  // nibble select for the active digit
  always_comb begin
    nib_s = disp_r[3:0];
    case (idx_r)
      2'd0:    nib_s = disp_r[3:0];
      2'd1:    nib_s = disp_r[7:4];
      2'd2:    nib_s = disp_r[11:8];
      2'd3:    nib_s = disp_r[15:12];
      default: nib_s = disp_r[3:0];
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble (nib_s),
    .seg    (dec_s)
  );

`ifdef DISP_LEAD_BLANK_EN
  logic blank_s;

  // leading zeros from the top digit down are blanked; digit 0 always shows
  always_comb begin
    blank_s = 1'b0;
    case (idx_r)
      2'd3:    blank_s = (disp_r[15:12] == 4'h0);
      2'd2:    blank_s = (disp_r[15:8] == 8'h00);
      2'd1:    blank_s = (disp_r[15:4] == 12'h000);
      default: blank_s = 1'b0;
    endcase
  end

  assign seg_s = blank_s ? SEG_BLANK : dec_s;
`else
  assign seg_s = dec_s;
`endif

  // registered digit drive, dark until the scan has started
  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
    end else if (lit_r) begin
      an_r  <= ~(4'b0001 << idx_r);
      seg_r <= seg_s;
    end else begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
    end
  end

  assign GNT0  = gnt0_r;
  assign GNT1  = gnt1_r;
  assign OWNER = owner_r;
  assign AN4   = an_r;
  assign SEG7  = seg_r;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: default-dwell instance plus a DWELL_TICKS=0 instance.
module tb_disp_arbiter;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_0  = 7'b1000000;
  localparam logic [6:0] S_1  = 7'b1111001;
  localparam logic [6:0] S_2  = 7'b0100100;
  localparam logic [6:0] S_3  = 7'b0110000;
  localparam logic [6:0] S_4  = 7'b0011001;
  localparam logic [6:0] S_9  = 7'b0010000;
  localparam logic [6:0] S_A  = 7'b0001000;
`ifdef DISP_LEAD_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk, rst, en, req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, owner;
  logic [3:0]  an;
  logic [6:0]  seg;

  logic        rst_z, req0_z, req1_z;
  logic [15:0] data0_z, data1_z;
  logic        gnt0_z, gnt1_z, owner_z;
  logic [3:0]  an_z;
  logic [6:0]  seg_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [2:0] exp;   // {GNT0, GNT1, OWNER}
  } vec_t;

  vec_t tbl [12];

  disp_arbiter u_dut (
    .CLK(clk), .RESET(rst), .EN240(en),
    .REQ0(req0), .DATA0(data0), .REQ1(req1), .DATA1(data1),
    .GNT0(gnt0), .GNT1(gnt1), .OWNER(owner), .AN4(an), .SEG7(seg)
  );

  disp_arbiter #(.DWELL_TICKS(0)) u_dutz (
    .CLK(clk), .RESET(rst_z), .EN240(en),
    .REQ0(req0_z), .DATA0(data0_z), .REQ1(req1_z), .DATA1(data1_z),
    .GNT0(gnt0_z), .GNT1(gnt1_z), .OWNER(owner_z), .AN4(an_z), .SEG7(seg_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    en = 1'b1;
    step();
    en = 1'b0;
    step();
  endtask

  initial begin
    int bad;
    tbl[0]  = '{1'b0, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 1'b1, 3'b011};
    tbl[2]  = '{1'b0, 1'b1, 3'b011};
    tbl[3]  = '{1'b1, 1'b1, 3'b100};
    tbl[4]  = '{1'b1, 1'b1, 3'b011};
    tbl[5]  = '{1'b1, 1'b0, 3'b100};
    tbl[6]  = '{1'b0, 1'b0, 3'b000};
    tbl[7]  = '{1'b1, 1'b1, 3'b011};
    tbl[8]  = '{1'b0, 1'b0, 3'b001};
    tbl[9]  = '{1'b1, 1'b1, 3'b100};
    tbl[10] = '{1'b0, 1'b0, 3'b000};
    tbl[11] = '{1'b1, 1'b0, 3'b100};

    rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 16'h0000; data1 = 16'h0000;
    rst_z = 1'b1; req0_z = 1'b0; req1_z = 1'b0; data0_z = 16'h0000; data1_z = 16'h0000;
    @(negedge clk);

    // reset for three cycles, display dark until the first EN240
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("rst_gnt", {gnt0, gnt1, owner}, 3'b000);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, S_BL);
    step(); step(); step();
    chk("dark_an", {an, seg}, {4'b1111, S_BL});
    tick();
    chk("first_tick", {an, seg}, {4'b1110, S_0});

    // single requester, latency 1, then scan through 16'h1234
    req0 = 1'b1; data0 = 16'h1234;
    step();
    chk("req0_lat", {gnt0, gnt1, owner}, 3'b100);
    step(); step();
    chk("dig0_4", {an, seg}, {4'b1110, S_4});
    tick();
    chk("dig1_3", {an, seg}, {4'b1101, S_3});
    tick();
    chk("dig2_2", {an, seg}, {4'b1011, S_2});
    tick();
    chk("dig3_1", {an, seg}, {4'b0111, S_1});
    tick();
    chk("wrap_4", {an, seg}, {4'b1110, S_4});

    // simultaneous requests after reset, preemption after 120 ticks
    req0 = 1'b0;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; data1 = 16'hBEEF;
    step();
    chk("tie_first", {gnt0, gnt1, owner}, 3'b100);
    bad = 0;
    for (int k = 1; k <= 120; k++) begin
      en = 1'b1;
      step();
      en = 1'b0;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) bad++;
      if (k < 120) begin
        step();
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) bad++;
      end
    end
    chk("dwell_hold", bad, 0);
    step();
    chk("dwell_swap", {gnt0, gnt1, owner}, 3'b011);

    // reset with EN240 and requests active during GRANT1
    step(); step();
    rst = 1'b1; en = 1'b1;
    step();
    chk("rst_mid_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_mid_disp", {an, seg}, {4'b1111, S_BL});
    en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    rst = 1'b0;
    step();
    tick();
    chk("rst_disp_clr", {an, seg}, {4'b1110, S_0});

    // leading-zero handling on 16'h00A0 and 16'h0000
    rst = 1'b1;
    step();
    rst = 1'b0; req1 = 1'b1; data1 = 16'h00A0;
    step(); step();
    tick();
    chk("a0_d0", {an, seg}, {4'b1110, S_0});
    tick();
    chk("a0_d1", {an, seg}, {4'b1101, S_A});
    tick();
    chk("a0_d2", {an, seg}, {4'b1011, (LB ? S_BL : S_0)});
    tick();
    chk("a0_d3", {an, seg}, {4'b0111, (LB ? S_BL : S_0)});
    data1 = 16'h0000;
    tick();
    chk("z_d0", {an, seg}, {4'b1110, S_0});
    tick();
    chk("z_d1", {an, seg}, {4'b1101, (LB ? S_BL : S_0)});
    req1 = 1'b0;

    // DWELL_TICKS=0 instance: arbitration table
    step();
    rst_z = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req0_z = tbl[i].r0;
      req1_z = tbl[i].r1;
      step();
      chk($sformatf("tbl%0d", i), {gnt0_z, gnt1_z, owner_z}, tbl[i].exp);
    end

    // DWELL_TICKS=0: immediate preemption and display switch
    req0_z = 1'b0; req1_z = 1'b1; data1_z = 16'h0003; data0_z = 16'h0009;
    step();
    chk("z_g1", {gnt0_z, gnt1_z}, 2'b01);
    tick();
    chk("z_show3", {an_z, seg_z}, {4'b1110, S_3});
    req0_z = 1'b1;
    step();
    chk("z_preempt", {gnt0_z, gnt1_z}, 2'b10);
    req1_z = 1'b0;
    step();
    chk("z_still3", seg_z, S_3);
    step();
    chk("z_show9", seg_z, S_9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
